// File: rtl/four_fulladd_full_adder.sv
// One ripple stage of the 4-bit adder: sum and carry for a single bit position.
// Carry uses the propagate form so the XOR term is shared with the sum.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/four_fulladd.sv
// 4-bit unsigned ripple-carry adder with carry-in; the 5-bit result
// {cout,s3,s2,s1,s0} is registered, so it appears one clock after the operands.
module four_fulladd (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3
);

    localparam int WIDTH = 4;

    // carry[i] feeds stage i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            {cout, s3, s2, s1, s0} <= '0;
        end else begin
            {cout, s3, s2, s1, s0} <= {carry[WIDTH], sum};
        end
    end

endmodule

// File: tb/tb_four_fulladd.sv
// Self-checking bench for four_fulladd: directed cases, exhaustive sweep and
// randomized traffic with resets, compared against plain integer arithmetic.
module tb_four_fulladd;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       cout;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       s3;

    int checks;
    int errors;

    four_fulladd dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .cout (cout),
        .s0   (s0),
        .s1   (s1),
        .s2   (s2),
        .s3   (s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: total = a + b + cin as an integer; low nibble is the sum,
    // anything at or above 16 sets cout. Reset forces zero.
    function automatic logic [4:0] model(input logic r, input int av, input int bv, input int cv);
        int total;
        total = av + bv + cv;
        if (r) return 5'd0;
        return {(total >= 16) ? 1'b1 : 1'b0, 4'(total % 16)};
    endfunction

    function automatic logic [4:0] observed();
        return {cout, s3, s2, s1, s0};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive operands, let one rising edge capture them, then compare #1 later.
    task automatic step(input string tag, input logic r, input logic [3:0] av,
                        input logic [3:0] bv, input logic cv);
        rst = r;
        a   = av;
        b   = bv;
        cin = cv;
        @(posedge clk);
        #1;
        check(tag, observed(), model(r, int'(av), int'(bv), int'(cv)));
    endtask

    initial begin
        logic [4:0] held;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = 4'd0;
        b   = 4'd0;
        cin = 1'b0;
        @(negedge clk);

        // Reset wins even with the largest operands present.
        step("reset_max_operands", 1'b1, 4'd15, 4'd15, 1'b1);
        check("reset_literal_zero", observed(), 5'b00000);

        // First edge after reset release captures the operands at that edge.
        step("zero",        1'b0, 4'd0, 4'd0, 1'b0);
        step("single",      1'b0, 4'd5, 4'd0, 1'b0);
        check("single_literal", observed(), 5'b00101);
        step("carry_in",    1'b0, 4'd5, 4'd8, 1'b1);
        check("carry_in_literal", observed(), 5'b01110);
        step("overflow",    1'b0, 4'd9, 4'd8, 1'b1);
        check("overflow_literal", observed(), 5'b10010);
        step("max_total",   1'b0, 4'd15, 4'd15, 1'b1);
        check("max_literal", observed(), 5'b11111);
        step("exact_16",    1'b0, 4'd8, 4'd8, 1'b0);

        // Outputs hold between edges while inputs toggle.
        held = observed();
        a   = 4'd3;
        b   = 4'd12;
        cin = 1'b1;
        #3;
        check("stable_between_edges", observed(), held);
        @(negedge clk);

        // Mid-stream reset drops the pending result, then traffic resumes.
        step("midstream_reset", 1'b1, 4'd7, 4'd9, 1'b1);
        step("after_release",   1'b0, 4'd14, 4'd1, 1'b1);

        // Exhaustive back-to-back sweep of every a, b, cin combination.
        for (int i = 0; i < 512; i++) begin
            step("sweep", 1'b0, 4'(i[3:0]), 4'(i[7:4]), i[8]);
        end

        // Randomized traffic with occasional reset and stability probes.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            r  = ($urandom_range(0, 15) == 0);
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            step("random", r, ra, rb, rc);
            if ((i % 25) == 0) begin
                held = observed();
                a   = ~ra;
                b   = ~rb;
                cin = ~rc;
                rst = ~r;
                #2;
                check("random_stable", observed(), held);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
